// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO (clause 22) management responder.
package mdio_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned POS_W  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam logic [ADDR_W-1:0] REG_CTRL   = 5'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS = 5'd1;
    localparam logic [ADDR_W-1:0] REG_ID1    = 5'd2;
    localparam logic [ADDR_W-1:0] REG_ID2    = 5'd3;

    // Frame bit positions counted from the first ST bit (0) to the last data bit (31).
    localparam logic [POS_W-1:0] POS_OP_END  = 5'd3;
    localparam logic [POS_W-1:0] POS_PHY_END = 5'd8;
    localparam logic [POS_W-1:0] POS_REG_END = 5'd13;
    localparam logic [POS_W-1:0] POS_TA0     = 5'd14;
    localparam logic [POS_W-1:0] POS_LAST    = 5'd31;

endpackage

// File: rtl/mdio_sync.sv
// Brings MDC and MDIO into the CLK domain and flags MDC rising events.
module mdio_sync (
    input  logic CLK,
    input  logic RST,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdc_rise_c,
    output logic o_mdio
);

    logic [1:0] r_mdc_ff;
    logic       r_mdc_prev;
    logic [1:0] r_mdio_ff;

    // Reset high so an MDC already high at reset release is not seen as a rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mdc_ff   <= 2'b11;
            r_mdc_prev <= 1'b1;
            r_mdio_ff  <= 2'b11;
        end else begin
            r_mdc_ff   <= {r_mdc_ff[0], i_mdc};
            r_mdc_prev <= r_mdc_ff[1];
            r_mdio_ff  <= {r_mdio_ff[0], i_mdio};
        end
    end

    assign o_mdc_rise_c = r_mdc_ff[1] & ~r_mdc_prev;
    assign o_mdio       = r_mdio_ff[1];

endmodule

// File: rtl/mdio_responder.sv
// MDIO frame decoder with a control register, live status and fixed PHY ID registers.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [15:0] CTRL_INIT = 16'h1140,
    parameter logic [15:0] PHY_ID1   = 16'h0000,
    parameter logic [15:0] PHY_ID2   = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  PHYAD,
    input  logic        MDC,
    input  logic        MDIO_IN,
    input  logic [15:0] STATUS,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] CTRL,
    output logic        CTRL_WR,
    output logic        FRAME_ERR
);

    logic w_rise;
    logic w_mdio;

    mdio_sync u_sync (
        .CLK          (CLK),
        .RST          (RST),
        .i_mdc        (MDC),
        .i_mdio       (MDIO_IN),
        .o_mdc_rise_c (w_rise),
        .o_mdio       (w_mdio)
    );

    state_t              r_state;
    logic [POS_W-1:0]    r_pos;
    logic                r_pre;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_phy;
    logic [ADDR_W-1:0]   r_regad;
    logic                r_ta;
    logic [DATA_W-1:0]   r_shift;
    logic                r_oe;
    logic                r_out;
    logic [DATA_W-1:0]   r_ctrl;
    logic                r_ctrl_wr;
    logic                r_frame_err;
    logic                r_wr_pend;

    state_t              w_state_nxt;
    logic [POS_W-1:0]    w_pos_nxt;
    logic                w_pre_nxt;
    logic [1:0]          w_op_nxt;
    logic [ADDR_W-1:0]   w_phy_nxt;
    logic [ADDR_W-1:0]   w_regad_nxt;
    logic                w_ta_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_oe_nxt;
    logic                w_out_nxt;
    logic [DATA_W-1:0]   w_ctrl_nxt;
    logic                w_ctrl_wr_nxt;
    logic                w_frame_err_nxt;
    logic                w_wr_pend_nxt;
    logic [DATA_W-1:0]   w_rd_val;

    always_comb begin
        unique case (r_regad)
            REG_CTRL:   w_rd_val = r_ctrl;
            REG_STATUS: w_rd_val = STATUS;
            REG_ID1:    w_rd_val = PHY_ID1;
            REG_ID2:    w_rd_val = PHY_ID2;
            default:    w_rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_pre       <= 1'b0;
            r_op        <= '0;
            r_phy       <= '0;
            r_regad     <= '0;
            r_ta        <= 1'b0;
            r_shift     <= '0;
            r_oe        <= 1'b0;
            r_out       <= 1'b1;
            r_ctrl      <= CTRL_INIT;
            r_ctrl_wr   <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_pre       <= w_pre_nxt;
            r_op        <= w_op_nxt;
            r_phy       <= w_phy_nxt;
            r_regad     <= w_regad_nxt;
            r_ta        <= w_ta_nxt;
            r_shift     <= w_shift_nxt;
            r_oe        <= w_oe_nxt;
            r_out       <= w_out_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_ctrl_wr   <= w_ctrl_wr_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_wr_pend   <= w_wr_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_pre_nxt       = r_pre;
        w_op_nxt        = r_op;
        w_phy_nxt       = r_phy;
        w_regad_nxt     = r_regad;
        w_ta_nxt        = r_ta;
        w_shift_nxt     = r_shift;
        w_oe_nxt        = r_oe;
        w_out_nxt       = r_out;
        w_ctrl_nxt      = r_ctrl;
        w_ctrl_wr_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_wr_pend_nxt   = 1'b0;

        // Write commit runs one cycle after the last data sample; bit 15 is a self-clearing soft reset.
        if (r_wr_pend) begin
            w_ctrl_wr_nxt = 1'b1;
            w_ctrl_nxt    = r_shift[15] ? CTRL_INIT : r_shift;
        end

        if (w_rise) begin
            w_pos_nxt = r_pos + POS_W'(1);
            case (r_state)
                S_IDLE: begin
                    w_pos_nxt = r_pos;
                    if (w_mdio) begin
                        w_pre_nxt = 1'b1;
                    end else if (r_pre) begin
                        w_pre_nxt   = 1'b0;
                        w_pos_nxt   = POS_W'(1);
                        w_state_nxt = S_ST;
                    end
                end
                S_ST: begin
                    if (w_mdio) begin
                        w_state_nxt = S_OP;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end
                end
                S_OP: begin
                    w_op_nxt = {r_op[0], w_mdio};
                    if (r_pos == POS_OP_END) begin
                        if (w_op_nxt == OP_WRITE || w_op_nxt == OP_READ) begin
                            w_state_nxt = S_PHYAD;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                            w_state_nxt     = S_SKIP;
                        end
                    end
                end
                S_PHYAD: begin
                    w_phy_nxt = {r_phy[ADDR_W-2:0], w_mdio};
                    if (r_pos == POS_PHY_END) begin
                        w_state_nxt = S_REGAD;
                    end
                end
                S_REGAD: begin
                    w_regad_nxt = {r_regad[ADDR_W-2:0], w_mdio};
                    if (r_pos == POS_REG_END) begin
                        w_state_nxt = (r_phy == PHYAD) ? S_TA : S_SKIP;
                    end
                end
                S_TA: begin
                    if (r_op == OP_READ) begin
                        // First TA bit: take the bus driving 0 and snapshot the register.
                        if (r_pos == POS_TA0) begin
                            w_oe_nxt    = 1'b1;
                            w_out_nxt   = 1'b0;
                            w_shift_nxt = w_rd_val;
                        end else begin
                            w_out_nxt   = r_shift[15];
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        if (r_pos == POS_TA0) begin
                            w_ta_nxt = w_mdio;
                        end else if ({r_ta, w_mdio} == TA_WRITE) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                            w_state_nxt     = S_SKIP;
                        end
                    end
                end
                S_DATA: begin
                    if (r_op == OP_READ) begin
                        if (r_pos == POS_LAST) begin
                            w_oe_nxt    = 1'b0;
                            w_out_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_out_nxt   = r_shift[15];
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                        end
                    end else begin
                        w_shift_nxt = {r_shift[14:0], w_mdio};
                        if (r_pos == POS_LAST) begin
                            w_wr_pend_nxt = (r_regad == REG_CTRL);
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
                S_SKIP: begin
                    if (r_pos == POS_LAST) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign MDIO_OUT  = r_out;
    assign MDIO_OE   = r_oe;
    assign CTRL      = r_ctrl;
    assign CTRL_WR   = r_ctrl_wr;
    assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: acts as the MDIO station manager on a fixed-rate MDC.
module tb_mdio_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  PHYAD = 5'h01;
    logic        MDC = 1'b1;
    logic        MDIO_IN = 1'b1;
    logic [15:0] STATUS = 16'h796D;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] CTRL;
    logic        CTRL_WR;
    logic        FRAME_ERR;

    localparam logic [15:0] INIT_V = 16'h1140;
    localparam logic [15:0] ID1_V  = 16'h0022;
    localparam logic [15:0] ID2_V  = 16'h1622;

    mdio_responder #(
        .CTRL_INIT (INIT_V),
        .PHY_ID1   (ID1_V),
        .PHY_ID2   (ID2_V)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PHYAD     (PHYAD),
        .MDC       (MDC),
        .MDIO_IN   (MDIO_IN),
        .STATUS    (STATUS),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .CTRL      (CTRL),
        .CTRL_WR   (CTRL_WR),
        .FRAME_ERR (FRAME_ERR)
    );

    always #4 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
        logic [15:0] exp_ctrl;
        int          exp_wr;
        int          exp_err;
        int          exp_oe;
        logic [15:0] exp_rd;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_err  = 0;

    // Pulse counters for CTRL_WR and FRAME_ERR, sampled mid-cycle.
    always @(negedge CLK) begin
        if (CTRL_WR)   n_wr++;
        if (FRAME_ERR) n_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One MDC period: drive data while MDC is low, sample the DUT just before the rising edge.
    task automatic xfer_bit(input logic b, output logic s_out, output logic s_oe);
        MDIO_IN = b;
        MDC = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        s_out = MDIO_OUT;
        s_oe  = MDIO_OE;
        MDC = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    task automatic run_frame(input vec_t v, output logic [15:0] rd, output int oe_cnt, output logic ta_out);
        logic [31:0] f;
        logic so, soe;
        f = {2'b01, v.op, v.phy, v.regad, v.ta, v.data};
        if (v.op == 2'b10) f[17:0] = '1;
        rd = '0;
        ta_out = 1'b1;
        oe_cnt = 0;
        xfer_bit(1'b1, so, soe);
        xfer_bit(1'b1, so, soe);
        for (int i = 0; i < 32; i++) begin
            xfer_bit(f[31-i], so, soe);
            if (soe) oe_cnt++;
            if (i == 15) ta_out = so;
            if (i >= 16) rd = {rd[14:0], so};
        end
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int wr0, er0, oe;
        logic [15:0] rd;
        logic ta;
        wr0 = n_wr;
        er0 = n_err;
        run_frame(v, rd, oe, ta);
        chk({nm, ".ctrl"},     32'(CTRL),        32'(v.exp_ctrl));
        chk({nm, ".ctrl_wr"},  32'(n_wr - wr0),  32'(v.exp_wr));
        chk({nm, ".frame_err"},32'(n_err - er0), 32'(v.exp_err));
        chk({nm, ".oe_bits"},  32'(oe),          32'(v.exp_oe));
        chk({nm, ".oe_end"},   32'(MDIO_OE),     32'(0));
        if (v.exp_oe != 0) begin
            chk({nm, ".ta_bit"}, 32'(ta), 32'(0));
            chk({nm, ".rd"},     32'(rd), 32'(v.exp_rd));
        end
    endtask

    vec_t tbl[17];

    initial begin
        vec_t v;
        logic so, soe;
        logic [31:0] f;
        int wr0, er0;

        tbl[0]  = '{2'b01, 5'h01, 5'd0, 2'b10, 16'h1140, 16'h1140, 1, 0, 0,  16'h0000};
        tbl[1]  = '{2'b01, 5'h01, 5'd0, 2'b10, 16'h0140, 16'h0140, 1, 0, 0,  16'h0000};
        tbl[2]  = '{2'b01, 5'h01, 5'd0, 2'b10, 16'h8000, 16'h1140, 1, 0, 0,  16'h0000};
        tbl[3]  = '{2'b01, 5'h01, 5'd0, 2'b10, 16'h0100, 16'h0100, 1, 0, 0,  16'h0000};
        tbl[4]  = '{2'b10, 5'h01, 5'd1, 2'b11, 16'hFFFF, 16'h0100, 0, 0, 17, 16'h796D};
        tbl[5]  = '{2'b10, 5'h01, 5'd0, 2'b11, 16'hFFFF, 16'h0100, 0, 0, 17, 16'h0100};
        tbl[6]  = '{2'b10, 5'h01, 5'd2, 2'b11, 16'hFFFF, 16'h0100, 0, 0, 17, 16'h0022};
        tbl[7]  = '{2'b10, 5'h01, 5'd3, 2'b11, 16'hFFFF, 16'h0100, 0, 0, 17, 16'h1622};
        tbl[8]  = '{2'b10, 5'h01, 5'd5, 2'b11, 16'hFFFF, 16'h0100, 0, 0, 17, 16'h0000};
        tbl[9]  = '{2'b01, 5'h02, 5'd0, 2'b10, 16'h1234, 16'h0100, 0, 0, 0,  16'h0000};
        tbl[10] = '{2'b10, 5'h02, 5'd1, 2'b11, 16'hFFFF, 16'h0100, 0, 0, 0,  16'h0000};
        tbl[11] = '{2'b01, 5'h01, 5'd0, 2'b11, 16'h5555, 16'h0100, 0, 1, 0,  16'h0000};
        tbl[12] = '{2'b11, 5'h01, 5'd0, 2'b10, 16'h2222, 16'h0100, 0, 1, 0,  16'h0000};
        tbl[13] = '{2'b00, 5'h01, 5'd0, 2'b10, 16'h3333, 16'h0100, 0, 1, 0,  16'h0000};
        tbl[14] = '{2'b01, 5'h01, 5'd0, 2'b10, 16'h0000, 16'h0000, 1, 0, 0,  16'h0000};
        tbl[15] = '{2'b01, 5'h01, 5'd4, 2'b10, 16'hFFFF, 16'h0000, 0, 0, 0,  16'h0000};
        tbl[16] = '{2'b01, 5'h01, 5'd0, 2'b10, 16'h0A5A, 16'h0A5A, 1, 0, 0,  16'h0000};

        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.ctrl",      32'(CTRL),      32'(INIT_V));
        chk("rst.oe",        32'(MDIO_OE),   32'(0));
        chk("rst.out",       32'(MDIO_OUT),  32'(1));
        chk("rst.ctrl_wr",   32'(n_wr),      32'(0));
        chk("rst.frame_err", 32'(n_err),     32'(0));

        for (int i = 0; i < 17; i++) begin
            apply_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Bad start-of-frame (preamble then 0,0) must flag an error and leave the responder ready.
        er0 = n_err;
        xfer_bit(1'b1, so, soe);
        xfer_bit(1'b1, so, soe);
        xfer_bit(1'b0, so, soe);
        xfer_bit(1'b0, so, soe);
        chk("st_err.frame_err", 32'(n_err - er0), 32'(1));
        v = '{2'b10, 5'h01, 5'd0, 2'b11, 16'hFFFF, 16'h0A5A, 0, 0, 17, 16'h0A5A};
        apply_vec(v, "after_st_err");

        // Reset while the DUT is driving read data bit 8 of register 1.
        wr0 = n_wr;
        er0 = n_err;
        f = {2'b01, 2'b10, 5'h01, 5'd1, 18'h3FFFF};
        xfer_bit(1'b1, so, soe);
        xfer_bit(1'b1, so, soe);
        for (int i = 0; i < 23; i++) begin
            xfer_bit(f[31-i], so, soe);
        end
        chk("mid_rst.oe_before",  32'(MDIO_OE),  32'(1));
        chk("mid_rst.bit8",       32'(MDIO_OUT), 32'(STATUS[8]));
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid_rst.oe",   32'(MDIO_OE),  32'(0));
        chk("mid_rst.out",  32'(MDIO_OUT), 32'(1));
        chk("mid_rst.ctrl", 32'(CTRL),     32'(INIT_V));
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_rst.ctrl_wr",   32'(n_wr - wr0),  32'(0));
        chk("mid_rst.frame_err", 32'(n_err - er0), 32'(0));
        v = '{2'b10, 5'h01, 5'd2, 2'b11, 16'hFFFF, INIT_V, 0, 0, 17, ID1_V};
        apply_vec(v, "after_rst_rd2");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
